exa_vc_packet_source: RTL and testbench
=======================================

EXA_VC_PACKET_SOURCE -- requirements
Module: exa_vc_packet_source

Interface
REQ-001 SHALL have parameter PRIO_NUM, default 2, number of priority levels.
REQ-002 SHALL have parameter VC_NUM, default 2, virtual channels per priority; NCH = VC_NUM*PRIO_NUM channels, CW = $clog2(NCH).
REQ-003 SHALL have parameter PAYLOAD_FLITS, default 16, payload words per packet (packet = header + PAYLOAD_FLITS + footer = 18 words by default).
REQ-004 SHALL have parameter PKT_LIMIT, default 0, packets per channel before that channel stops (0 = unlimited).
REQ-005 SHALL have clk  input  1  single clock, all logic on rising edge.
REQ-006 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have i_enable  input  1  permits starting new packets.
REQ-008 SHALL have i_vc_mask  input  NCH  channel n eligible when bit n = 1.
REQ-009 SHALL have o_header_valid / i_header_ready  out/in  1  header handshake.
REQ-010 SHALL have o_payload_valid / i_payload_ready  out/in  1  payload handshake.
REQ-011 SHALL have o_footer_valid / i_footer_ready  out/in  1  footer handshake.
REQ-012 SHALL have o_data  output  128  current flit.
REQ-013 SHALL have o_vc  output  CW  channel of the packet in flight, stable header through footer.
REQ-014 SHALL have o_busy  output  1  high in any state other than IDLE.
REQ-015 SHALL have o_done  output  1  high when PKT_LIMIT != 0 and every channel has sent PKT_LIMIT packets.

Function
REQ-016 SHALL implement FSM IDLE -> HDR -> PLD -> FTR -> IDLE; a transfer occurs only when valid and ready are both high on a rising edge.
REQ-017 SHALL, in IDLE, grant when i_enable = 1 and some channel n has i_vc_mask[n] = 1 and is not exhausted; grant = first such channel after last-granted in round-robin order (wrap NCH-1 -> 0); latch grant into o_vc; next state HDR.
REQ-018 SHALL assert exactly one of the three valids in HDR/PLD/FTR respectively, never more than one, none in IDLE.
REQ-019 SHALL hold valid, o_data and o_vc stable while valid is high and ready is low.
REQ-020 SHALL format o_data = {32'(o_vc), pkt_cnt[o_vc], 32'(flit_idx), 32'h5A5A_5A5A}; flit_idx 0 = header, 1..PAYLOAD_FLITS = payload, PAYLOAD_FLITS+1 = footer.
REQ-021 SHALL move HDR -> PLD on header transfer with flit_idx = 1; in PLD increment flit_idx per transfer and move to FTR on the transfer of flit_idx = PAYLOAD_FLITS.
REQ-022 SHALL, on footer transfer, increment 32-bit pkt_cnt[o_vc] (wrapping 0xFFFF_FFFF -> 0) and return to IDLE; minimum one IDLE cycle between packets.
REQ-023 SHALL treat channel n as exhausted when PKT_LIMIT != 0 and pkt_cnt[n] == PKT_LIMIT.
REQ-024 SHALL complete a started packet regardless of i_enable or i_vc_mask changes after grant.
REQ-025 SHALL remain in IDLE with no valids if no channel is eligible.
REQ-026 SHALL drive o_data = 0 in IDLE.

Reset
REQ-027 SHALL, on rst = 1 at a clock edge, enter IDLE, clear all valids, o_data, o_vc, o_busy, o_done, every pkt_cnt and flit_idx, and set the round-robin pointer so the next grant search starts at channel 0.
REQ-028 SHALL abandon any packet in flight on reset (no footer sent); rst overrides every handshake in the same cycle.

Verification
REQ-029 Defaults, ready tied 1, i_vc_mask = 4'b1111, i_enable = 1 -> packets on o_vc 0,1,2,3,0..., each 18 consecutive transfers then 1 idle cycle; 2nd packet header o_data = {32'd1, 32'd0, 32'd0, 32'h5A5A5A5A}.
REQ-030 Random readies (~50%) -> o_data/o_vc never change while valid high and ready low; every packet has flit_idx 0..17 in order.
REQ-031 i_vc_mask = 4'b0100 -> only o_vc = 2; pkt_cnt field 0,1,2...; i_vc_mask = 0 -> no valids, o_busy = 0.
REQ-032 PKT_LIMIT = 3, mask 4'b1111 -> exactly 12 packets, 3 per channel, then o_done = 1 and no valids.
REQ-033 i_enable dropped during payload flit 5 -> packet completes through footer, no new header until i_enable = 1.
REQ-034 rst pulsed during flit 9 of channel 1 -> next cycle all valids 0; next packet is channel 0 with pkt_cnt field 0.

Source files
------------

// File: rtl/exa_vc_packet_source.sv
// Packet generator: round-robin over NCH virtual channels, emits
// header / PAYLOAD_FLITS payload words / footer on three independent
// valid-ready handshakes, with an optional per-channel packet limit.
module exa_vc_packet_source #(
   parameter  int PRIO_NUM      = 2,
   parameter  int VC_NUM        = 2,
   parameter  int PAYLOAD_FLITS = 16,
   parameter  int PKT_LIMIT     = 0,
   localparam int NCH           = VC_NUM * PRIO_NUM,
   localparam int CW            = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           i_enable,
   input  logic [NCH-1:0] i_vc_mask,
   output logic           o_header_valid,
   input  logic           i_header_ready,
   output logic           o_payload_valid,
   input  logic           i_payload_ready,
   output logic           o_footer_valid,
   input  logic           i_footer_ready,
   output logic [127:0]   o_data,
   output logic [CW-1:0]  o_vc,
   output logic           o_busy,
   output logic           o_done
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_HDR,
      S_PLD,
      S_FTR
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] vc_q, vc_d;
   logic [CW-1:0] last_q, last_d;
   logic [31:0]   flit_q, flit_d;
   logic [31:0]   cnt_q [NCH];
   logic [31:0]   cnt_d [NCH];

   logic [NCH-1:0] exhausted;
   logic           grant_found;
   logic [CW-1:0]  grant_vc;

   // Channel n is exhausted once it has sent PKT_LIMIT packets (limit 0 = never).
   always_comb begin
      exhausted = '0;
      for (int unsigned n = 0; n < NCH; n++) begin
         exhausted[n] = (PKT_LIMIT != 0) && (cnt_q[n] == 32'(PKT_LIMIT));
      end
   end

   // Round-robin search: first eligible channel strictly after last_q, wrapping.
   always_comb begin
      int unsigned idx;
      idx         = 0;
      grant_found = 1'b0;
      grant_vc    = '0;
      for (int unsigned k = 1; k <= NCH; k++) begin
         idx = (32'(last_q) + k) % NCH;
         if (!grant_found && i_vc_mask[idx] && !exhausted[idx]) begin
            grant_found = 1'b1;
            grant_vc    = CW'(idx);
         end
      end
   end

   // Next-state logic: packet sequencing, flit index and packet counters.
   always_comb begin
      state_d = state_q;
      vc_d    = vc_q;
      last_d  = last_q;
      flit_d  = flit_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (i_enable && grant_found) begin
               state_d = S_HDR;
               vc_d    = grant_vc;
               last_d  = grant_vc;
               flit_d  = '0;
            end
         end
         S_HDR: begin
            if (i_header_ready) begin
               // With no payload words the footer index is 1 as well.
               state_d = (PAYLOAD_FLITS == 0) ? S_FTR : S_PLD;
               flit_d  = 32'd1;
            end
         end
         S_PLD: begin
            if (i_payload_ready) begin
               flit_d = flit_q + 32'd1;
               if (flit_q == 32'(PAYLOAD_FLITS)) begin
                  state_d = S_FTR;
               end
            end
         end
         S_FTR: begin
            if (i_footer_ready) begin
               cnt_d[vc_q] = cnt_q[vc_q] + 32'd1;
               flit_d      = '0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State registers; reset abandons any packet in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         vc_q    <= '0;
         last_q  <= CW'(NCH - 1);
         flit_q  <= '0;
         for (int unsigned n = 0; n < NCH; n++) begin
            cnt_q[n] <= '0;
         end
      end else begin
         state_q <= state_d;
         vc_q    <= vc_d;
         last_q  <= last_d;
         flit_q  <= flit_d;
         cnt_q   <= cnt_d;
      end
   end

   // Outputs depend only on registered state, so they hold while stalled.
   always_comb begin
      o_header_valid  = (state_q == S_HDR);
      o_payload_valid = (state_q == S_PLD);
      o_footer_valid  = (state_q == S_FTR);
      o_busy          = (state_q != S_IDLE);
      o_vc            = vc_q;
      o_done          = (PKT_LIMIT != 0) && (&exhausted);
      o_data          = '0;
      if (state_q != S_IDLE) begin
         o_data = {32'(vc_q), cnt_q[vc_q], flit_q, 32'h5A5A_5A5A};
      end
   end

endmodule

// File: tb/tb_exa_vc_packet_source.sv
// Directed bench for exa_vc_packet_source: default instance plus a
// PKT_LIMIT=3 instance for the exhaustion scenario.
module tb_exa_vc_packet_source;

   localparam int PKT = 18;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // default instance
   logic         rst, en, hr, pr, fr;
   logic [3:0]   mask;
   logic         hv, pv, fv, busy, done;
   logic [127:0] data;
   logic [1:0]   vc;

   // PKT_LIMIT = 3 instance
   logic         rst_l, en_l, rdy_l;
   logic [3:0]   mask_l;
   logic         hv_l, pv_l, fv_l, busy_l, done_l;
   logic [127:0] data_l;
   logic [1:0]   vc_l;

   exa_vc_packet_source dut (
      .clk(clk), .rst(rst), .i_enable(en), .i_vc_mask(mask),
      .o_header_valid(hv), .i_header_ready(hr),
      .o_payload_valid(pv), .i_payload_ready(pr),
      .o_footer_valid(fv), .i_footer_ready(fr),
      .o_data(data), .o_vc(vc), .o_busy(busy), .o_done(done)
   );

   exa_vc_packet_source #(.PKT_LIMIT(3)) dut_lim (
      .clk(clk), .rst(rst_l), .i_enable(en_l), .i_vc_mask(mask_l),
      .o_header_valid(hv_l), .i_header_ready(rdy_l),
      .o_payload_valid(pv_l), .i_payload_ready(rdy_l),
      .o_footer_valid(fv_l), .i_footer_ready(rdy_l),
      .o_data(data_l), .o_vc(vc_l), .o_busy(busy_l), .o_done(done_l)
   );

   int n_checks = 0;
   int n_pass   = 0;

   logic [127:0] cap_data [PKT];
   logic [2:0]   cap_vld  [PKT];
   logic [1:0]   cap_vc   [PKT];
   logic [2:0]   cap_idle_vld;
   logic         cap_idle_busy;
   int           cap_wait;
   bit           cap_to;

   function automatic logic [127:0] fw(input int unsigned v, input int unsigned c,
                                       input int unsigned f);
      return {v, c, f, 32'h5A5A_5A5A};
   endfunction

   function automatic logic [2:0] ev(input int unsigned f);
      if (f == 0) return 3'b100;
      if (f == PKT - 1) return 3'b001;
      return 3'b010;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Waits (bounded) for a header, then records 18 flits and the following cycle.
   task automatic capture_packet();
      cap_to   = 1'b0;
      cap_wait = 0;
      while (!hv && cap_wait < 50) begin
         @(negedge clk);
         cap_wait++;
      end
      if (!hv) begin
         cap_to = 1'b1;
         return;
      end
      for (int f = 0; f < PKT; f++) begin
         cap_data[f] = data;
         cap_vld[f]  = {hv, pv, fv};
         cap_vc[f]   = vc;
         @(negedge clk);
      end
      cap_idle_vld  = {hv, pv, fv};
      cap_idle_busy = busy;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1; rst_l = 1'b1;
      mask = 4'b1111; en = 1'b1; hr = 1'b1; pr = 1'b1; fr = 1'b1;
      @(negedge clk);
      @(negedge clk);
      n_checks++;
      if ({hv, pv, fv, busy, done} !== 5'b0) $display("FAIL reset_flags got %b want 00000", {hv, pv, fv, busy, done});
      else n_pass++;
      n_checks++;
      if ({vc, data} !== '0) $display("FAIL reset_data got vc=%0d data=%h want 0", vc, data);
      else n_pass++;
      n_checks++;
      if ({hv_l, pv_l, fv_l, busy_l, done_l} !== 5'b0) $display("FAIL reset_lim_flags got %b want 00000", {hv_l, pv_l, fv_l, busy_l, done_l});
      else n_pass++;
      rst = 1'b0;
   endtask

   task automatic test_round_robin();
      do_reset();
      mask = 4'b1111; en = 1'b1; hr = 1'b1; pr = 1'b1; fr = 1'b1;
      for (int p = 0; p < 5; p++) begin
         capture_packet();
         if (cap_to) begin
            n_checks++;
            $display("FAIL rr_timeout p=%0d got no header want header", p);
            return;
         end
         if (p > 0) begin
            n_checks++;
            if (cap_wait !== 1) $display("FAIL rr_gap p=%0d got %0d idle cycles want 1", p, cap_wait);
            else n_pass++;
         end
         for (int f = 0; f < PKT; f++) begin
            n_checks++;
            if ({cap_vld[f], cap_vc[f], cap_data[f]} !== {ev(f), 2'(p % 4), fw(p % 4, p / 4, f)})
               $display("FAIL rr_flit p=%0d f=%0d got vld=%b vc=%0d data=%h want vld=%b vc=%0d data=%h",
                        p, f, cap_vld[f], cap_vc[f], cap_data[f], ev(f), p % 4, fw(p % 4, p / 4, f));
            else n_pass++;
         end
         n_checks++;
         if ({cap_idle_vld, cap_idle_busy} !== 4'b0) $display("FAIL rr_idle p=%0d got %b want 0000", p, {cap_idle_vld, cap_idle_busy});
         else n_pass++;
      end
   endtask

   task automatic test_backpressure();
      int unsigned ef, evc, pkts;
      bit r;
      do_reset();
      mask = 4'b1111; en = 1'b1;
      ef = 0; evc = 0; pkts = 0;
      for (int c = 0; c < 600 && pkts < 3; c++) begin
         r  = 1'($urandom_range(0, 1));
         hr = r; pr = r; fr = r;
         if (ef > 0 || hv || pv || fv) begin
            n_checks++;
            if ({hv, pv, fv, vc, data} !== {ev(ef), 2'(evc), fw(evc, 0, ef)})
               $display("FAIL bp_flit c=%0d got vld=%b vc=%0d data=%h want vld=%b vc=%0d data=%h",
                        c, {hv, pv, fv}, vc, data, ev(ef), evc, fw(evc, 0, ef));
            else n_pass++;
            if (r) begin
               ef++;
               if (ef == PKT) begin
                  ef = 0; pkts++; evc = (evc + 1) % 4;
               end
            end
         end
         @(negedge clk);
      end
      n_checks++;
      if (pkts !== 3) $display("FAIL bp_count got %0d packets want 3", pkts);
      else n_pass++;
      hr = 1'b1; pr = 1'b1; fr = 1'b1;
   endtask

   task automatic test_single_mask();
      int vld_cycles;
      do_reset();
      mask = 4'b0100; en = 1'b1; hr = 1'b1; pr = 1'b1; fr = 1'b1;
      for (int p = 0; p < 3; p++) begin
         capture_packet();
         if (cap_to) begin
            n_checks++;
            $display("FAIL sm_timeout p=%0d got no header want header", p);
            return;
         end
         for (int f = 0; f < PKT; f++) begin
            n_checks++;
            if ({cap_vld[f], cap_vc[f], cap_data[f]} !== {ev(f), 2'd2, fw(2, p, f)})
               $display("FAIL sm_flit p=%0d f=%0d got vld=%b vc=%0d data=%h want vld=%b vc=2 data=%h",
                        p, f, cap_vld[f], cap_vc[f], cap_data[f], ev(f), fw(2, p, f));
            else n_pass++;
         end
      end
      mask = 4'b0000;
      vld_cycles = 0;
      for (int c = 0; c < 30; c++) begin
         if (hv || pv || fv || busy) vld_cycles++;
         @(negedge clk);
      end
      n_checks++;
      if (vld_cycles !== 0) $display("FAIL sm_mask0 got %0d active cycles want 0", vld_cycles);
      else n_pass++;
   endtask

   task automatic test_enable_drop();
      int vld_cycles;
      do_reset();
      mask = 4'b1111; en = 1'b1; hr = 1'b1; pr = 1'b1; fr = 1'b1;
      for (int w = 0; w < 50 && !hv; w++) @(negedge clk);
      for (int f = 0; f < PKT; f++) begin
         n_checks++;
         if ({hv, pv, fv, data} !== {ev(f), fw(0, 0, f)})
            $display("FAIL en_flit f=%0d got vld=%b data=%h want vld=%b data=%h",
                     f, {hv, pv, fv}, data, ev(f), fw(0, 0, f));
         else n_pass++;
         if (f == 5) en = 1'b0;
         @(negedge clk);
      end
      vld_cycles = 0;
      for (int c = 0; c < 30; c++) begin
         if (hv || pv || fv) vld_cycles++;
         @(negedge clk);
      end
      n_checks++;
      if (vld_cycles !== 0) $display("FAIL en_hold got %0d valid cycles want 0", vld_cycles);
      else n_pass++;
      en = 1'b1;
      for (int w = 0; w < 10 && !hv; w++) @(negedge clk);
      n_checks++;
      if ({hv, data} !== {1'b1, fw(1, 0, 0)}) $display("FAIL en_resume got hv=%b data=%h want hv=1 data=%h", hv, data, fw(1, 0, 0));
      else n_pass++;
   endtask

   task automatic test_reset_midpacket();
      do_reset();
      mask = 4'b1111; en = 1'b1; hr = 1'b1; pr = 1'b1; fr = 1'b1;
      capture_packet();
      for (int w = 0; w < 10 && !hv; w++) @(negedge clk);
      for (int f = 0; f < 9; f++) @(negedge clk);
      n_checks++;
      if (data !== fw(1, 0, 9)) $display("FAIL rm_pos got %h want %h", data, fw(1, 0, 9));
      else n_pass++;
      rst = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({hv, pv, fv, busy, vc, data} !== '0) $display("FAIL rm_clear got vld=%b busy=%b vc=%0d data=%h want 0", {hv, pv, fv}, busy, vc, data);
      else n_pass++;
      rst = 1'b0;
      capture_packet();
      n_checks++;
      if (cap_to || {cap_vc[0], cap_data[0]} !== {2'd0, fw(0, 0, 0)})
         $display("FAIL rm_next got to=%b vc=%0d data=%h want vc=0 data=%h", cap_to, cap_vc[0], cap_data[0], fw(0, 0, 0));
      else n_pass++;
   endtask

   task automatic test_limit();
      int hdr [4];
      int total;
      for (int i = 0; i < 4; i++) hdr[i] = 0;
      mask_l = 4'b1111; en_l = 1'b1; rdy_l = 1'b1;
      @(negedge clk);
      rst_l = 1'b1;
      @(negedge clk);
      rst_l = 1'b0;
      for (int c = 0; c < 400; c++) begin
         if (hv_l) hdr[vc_l]++;
         if (c == 100) begin
            n_checks++;
            if (done_l !== 1'b0) $display("FAIL lim_done_early got %b want 0", done_l);
            else n_pass++;
         end
         @(negedge clk);
      end
      total = 0;
      for (int i = 0; i < 4; i++) begin
         total += hdr[i];
         n_checks++;
         if (hdr[i] !== 3) $display("FAIL lim_per_ch ch=%0d got %0d packets want 3", i, hdr[i]);
         else n_pass++;
      end
      n_checks++;
      if (total !== 12) $display("FAIL lim_total got %0d want 12", total);
      else n_pass++;
      n_checks++;
      if ({done_l, hv_l, pv_l, fv_l, busy_l} !== 5'b10000) $display("FAIL lim_end got done/vld/busy=%b want 10000", {done_l, hv_l, pv_l, fv_l, busy_l});
      else n_pass++;
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; mask = '0; hr = 1'b0; pr = 1'b0; fr = 1'b0;
      rst_l = 1'b1; en_l = 1'b0; mask_l = '0; rdy_l = 1'b0;
      test_reset();
      test_round_robin();
      test_backpressure();
      test_single_mask();
      test_enable_drop();
      test_reset_midpacket();
      test_limit();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
